// File: rtl/chdr_16sc_to_xsc.sv
// CHDR sc16 -> sc16/sc12/sc8 compressor; rewrites header length and optionally the SID.
// One registered output stage (1-cycle latency); i_tready drops on output stall and during the residual flush.
module chdr_16sc_to_xsc #(
  parameter int BASE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [63:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [63:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready
);
  localparam logic [7:0] ADDR_RT = 8'(BASE);
  localparam logic [7:0] ADDR_MD = 8'(BASE + 1);

  typedef enum logic [1:0] {S_HEAD, S_TIME, S_PAYLOAD, S_FLUSH} state_t;

  state_t         r_state, w_state_nxt;
  logic           r_sid_en;
  logic [15:0]    r_dest;
  logic [1:0]     r_mode;
  logic           r_round;
  logic [1:0]     r_lmode;
  logic           r_lround;
  logic           r_odd;
  logic [127:0]   r_acc, w_acc_nxt;
  logic [6:0]     r_cnt, w_cnt_nxt;
  logic [63:0]    r_odat;
  logic           r_olast, r_ovld;

  logic           w_adv, w_xfer, w_emit, w_elast, w_latch;
  logic [63:0]    w_edat;
  logic           w_ht;
  logic [15:0]    w_hlen, w_n, w_olen;
  logic [1:0]     w_cmode;
  logic [31:0]    w_sid;
  logic           w_part;
  logic [47:0]    w_pk;
  logic [6:0]     w_nlen, w_tot;
  logic [127:0]   w_sum;
  logic           w_unused_set;

  function automatic logic [11:0] f_cvt12(input logic [15:0] x, input logic rnd);
    logic [16:0] s;
    s = {x[15], x} + (rnd ? 17'd8 : 17'd0);
    if (s[16] != s[15]) return 12'h7FF;
    return s[15:4];
  endfunction

  function automatic logic [7:0] f_cvt8(input logic [15:0] x, input logic rnd);
    logic [16:0] s;
    s = {x[15], x} + (rnd ? 17'h80 : 17'd0);
    if (s[16] != s[15]) return 8'h7F;
    return s[15:8];
  endfunction

  assign w_unused_set = ^set_data[31:17];

  assign w_adv    = !r_ovld || o_tready;
  assign i_tready = !reset && (r_state != S_FLUSH) && w_adv;
  assign w_xfer   = i_tvalid && i_tready;

  assign o_tdata  = r_odat;
  assign o_tlast  = r_olast;
  assign o_tvalid = r_ovld;

  // Header rewrite uses the live config; it is latched for the payload at the same time.
  assign w_ht    = i_tdata[61];
  assign w_hlen  = w_ht ? 16'd16 : 16'd8;
  assign w_n     = (i_tdata[47:32] - w_hlen) >> 2;
  assign w_cmode = (r_mode == 2'd3) ? 2'd0 : r_mode;
  assign w_sid   = r_sid_en ? {i_tdata[15:0], r_dest} : i_tdata[31:0];

  always_comb begin
    case (w_cmode)
      2'd1:    w_olen = w_hlen + (w_n << 1) + w_n;
      2'd2:    w_olen = w_hlen + (w_n << 1);
      default: w_olen = w_hlen + (w_n << 2);
    endcase
  end

  // Converted samples left-aligned in 48 bits; the unused sample1 of an odd tail is zeroed.
  assign w_part = i_tlast && r_odd;

  always_comb begin
    if (r_lmode == 2'd1) begin
      w_pk = {f_cvt12(i_tdata[63:48], r_lround), f_cvt12(i_tdata[47:32], r_lround),
              f_cvt12(i_tdata[31:16], r_lround), f_cvt12(i_tdata[15:0], r_lround)};
      if (w_part) w_pk[23:0] = '0;
      w_nlen = w_part ? 7'd24 : 7'd48;
    end else begin
      w_pk = {f_cvt8(i_tdata[63:48], r_lround), f_cvt8(i_tdata[47:32], r_lround),
              f_cvt8(i_tdata[31:16], r_lround), f_cvt8(i_tdata[15:0], r_lround), 16'h0};
      if (w_part) w_pk[31:16] = '0;
      w_nlen = w_part ? 7'd16 : 7'd32;
    end
  end

  assign w_sum = r_acc | ({w_pk, 80'h0} >> r_cnt);
  assign w_tot = r_cnt + w_nlen;

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_edat      = '0;
    w_elast     = 1'b0;
    w_latch     = 1'b0;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_HEAD: begin
        if (w_xfer) begin
          w_latch   = 1'b1;
          w_emit    = 1'b1;
          w_edat    = {i_tdata[63:48], w_olen, w_sid};
          w_elast   = i_tlast;
          w_acc_nxt = '0;
          w_cnt_nxt = '0;
          if (i_tlast)   w_state_nxt = S_HEAD;
          else if (w_ht) w_state_nxt = S_TIME;
          else           w_state_nxt = S_PAYLOAD;
        end
      end
      S_TIME: begin
        if (w_xfer) begin
          w_emit      = 1'b1;
          w_edat      = i_tdata;
          w_elast     = i_tlast;
          w_state_nxt = i_tlast ? S_HEAD : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (w_xfer) begin
          if (r_lmode == 2'd0) begin
            w_emit  = 1'b1;
            w_edat  = i_tdata;
            w_elast = i_tlast;
            if (i_tlast) w_state_nxt = S_HEAD;
          end else if (w_tot >= 7'd64) begin
            w_emit    = 1'b1;
            w_edat    = w_sum[127:64];
            w_acc_nxt = w_sum << 64;
            w_cnt_nxt = w_tot - 7'd64;
            if (i_tlast) begin
              if (w_tot == 7'd64) begin
                w_elast     = 1'b1;
                w_state_nxt = S_HEAD;
              end else begin
                w_state_nxt = S_FLUSH;
              end
            end
          end else if (i_tlast) begin
            w_emit      = 1'b1;
            w_edat      = w_sum[127:64];
            w_elast     = 1'b1;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_HEAD;
          end else begin
            w_acc_nxt = w_sum;
            w_cnt_nxt = w_tot;
          end
        end
      end
      S_FLUSH: begin
        if (w_adv) begin
          w_emit      = 1'b1;
          w_edat      = r_acc[127:64];
          w_elast     = 1'b1;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_HEAD;
        end
      end
      default: w_state_nxt = S_HEAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sid_en <= 1'b0;
      r_dest   <= '0;
      r_mode   <= '0;
      r_round  <= 1'b0;
    end else if (set_stb) begin
      if (set_addr == ADDR_RT) begin
        r_sid_en <= set_data[16];
        r_dest   <= set_data[15:0];
      end
      if (set_addr == ADDR_MD) begin
        r_mode  <= set_data[1:0];
        r_round <= set_data[2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_HEAD;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_lmode  <= '0;
      r_lround <= 1'b0;
      r_odd    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_lmode  <= w_cmode;
        r_lround <= r_round;
        r_odd    <= w_n[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovld  <= 1'b0;
      r_olast <= 1'b0;
      r_odat  <= '0;
    end else if (w_adv) begin
      r_ovld <= w_emit;
      if (w_emit) begin
        r_odat  <= w_edat;
        r_olast <= w_elast;
      end
    end
  end

endmodule

// File: tb/tb_chdr_16sc_to_xsc.sv
// Scoreboard bench for chdr_16sc_to_xsc: directed packets, sc12 sweep, randomized packets and config,
// output backpressure and reset in the middle of a packet.
module tb_chdr_16sc_to_xsc;
  logic        clk, reset, set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [63:0] i_tdata, o_tdata;
  logic        i_tlast, i_tvalid, i_tready, o_tlast, o_tvalid, o_tready;

  chdr_16sc_to_xsc #(.BASE(0)) dut (
    .clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
  );

  typedef struct packed { logic [63:0] d; logic l; } exp_t;

  exp_t        sb[$];
  logic [63:0] pw[$];
  int          total = 0, bad = 0;
  bit          mon_en = 1, bp_on = 0, gap_on = 0;
  bit          cfg_sid_en = 0, cfg_round = 0;
  logic [15:0] cfg_dest = '0;
  logic [1:0]  cfg_mode = '0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      o_tready = bp_on ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: pops on every output handshake and checks that stalled outputs hold.
  initial begin
    bit          stall;
    logic [63:0] hd;
    logic        hl;
    exp_t        e;
    stall = 0;
    forever begin
      @(negedge clk);
      if (reset || !mon_en) begin
        stall = 0;
      end else begin
        if (stall) begin
          total++;
          if (o_tvalid !== 1'b1 || o_tdata !== hd || o_tlast !== hl) begin
            bad++;
            $display("FAIL hold: got v=%0b %h/%0b want v=1 %h/%0b", o_tvalid, o_tdata, o_tlast, hd, hl);
          end
        end
        stall = o_tvalid && !o_tready;
        hd = o_tdata;
        hl = o_tlast;
        if (o_tvalid && o_tready) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected word: got %h/%0b want none", o_tdata, o_tlast);
          end else begin
            e = sb.pop_front();
            if (o_tdata !== e.d || o_tlast !== e.l) begin
              bad++;
              $display("FAIL word: got %h/%0b want %h/%0b", o_tdata, o_tlast, e.d, e.l);
            end
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [63:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    sb.push_back(e);
  endtask

  function automatic logic [15:0] cnv(input logic [15:0] c, input int w, input bit rnd);
    int x, mx;
    logic [15:0] r;
    x = int'($signed(c));
    if (rnd) x = x + (1 << (15 - w));
    x = x >>> (16 - w);
    mx = (1 << (w - 1)) - 1;
    if (x > mx) x = mx;
    r = 16'(x);
    return r & ((16'd1 << w) - 16'd1);
  endfunction

  // Reference model: expected output words from the header, the timestamp and pw[].
  task automatic expect_pkt(input logic [63:0] hdr, input logic [63:0] ts);
    exp_t        wl[$];
    exp_t        t;
    bit          bq[$];
    int          ht, n, mode, bsz, w, nw;
    logic [31:0] sid, smp;
    logic [15:0] v;
    logic [63:0] wd;
    nw   = pw.size();
    ht   = int'(hdr[61]);
    n    = (int'(hdr[47:32]) - 8 - 8 * ht) / 4;
    mode = (cfg_mode == 2'd3) ? 0 : int'(cfg_mode);
    bsz  = (mode == 1) ? 3 : ((mode == 2) ? 2 : 4);
    sid  = cfg_sid_en ? {hdr[15:0], cfg_dest} : hdr[31:0];
    t.d = {hdr[63:48], 16'(8 + 8 * ht + n * bsz), sid};
    t.l = 1'b0;
    wl.push_back(t);
    if (ht != 0) begin
      t.d = ts;
      wl.push_back(t);
    end
    if (mode == 0) begin
      foreach (pw[k]) begin
        t.d = pw[k];
        wl.push_back(t);
      end
    end else begin
      w = (mode == 1) ? 12 : 8;
      for (int k = 0; k < nw; k++) begin
        for (int s = 0; s < 2; s++) begin
          if (!(s == 1 && k == nw - 1 && (n % 2) == 1)) begin
            smp = (s == 0) ? pw[k][63:32] : pw[k][31:0];
            for (int c = 0; c < 2; c++) begin
              v = cnv((c == 0) ? smp[31:16] : smp[15:0], w, cfg_round);
              for (int b = w - 1; b >= 0; b--) bq.push_back(v[b]);
            end
          end
        end
      end
      for (int i = 0; i < bq.size(); i += 64) begin
        wd = '0;
        for (int j = 0; j < 64; j++) if (i + j < bq.size()) wd[63 - j] = bq[i + j];
        t.d = wd;
        wl.push_back(t);
      end
    end
    t = wl.pop_back();
    t.l = 1'b1;
    wl.push_back(t);
    foreach (wl[i]) sb.push_back(wl[i]);
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1;
    set_addr = a;
    set_data = d;
    @(posedge clk);
    #1;
    set_stb = 1'b0;
    if (a == 8'd0) begin
      cfg_sid_en = d[16];
      cfg_dest = d[15:0];
    end else if (a == 8'd1) begin
      cfg_mode = d[1:0];
      cfg_round = d[2];
    end
  endtask

  task automatic send_word(input logic [63:0] d, input logic l);
    bit got;
    int cyc;
    if (gap_on) repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    i_tdata = d;
    i_tlast = l;
    i_tvalid = 1'b1;
    got = 0;
    cyc = 0;
    while (!got && cyc < 500) begin
      @(negedge clk);
      got = i_tready;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL accept timeout: got i_tready=0 want 1 within 500 cycles");
    end
    i_tvalid = 1'b0;
    i_tlast = 1'b0;
  endtask

  task automatic drive_pkt(input logic [63:0] hdr, input logic [63:0] ts, input bit mid_wr);
    int nw;
    nw = pw.size();
    send_word(hdr, nw == 0 && !hdr[61]);
    if (hdr[61]) send_word(ts, nw == 0);
    if (mid_wr) write_reg(8'd1, {29'h0, cfg_round, 2'd2});
    for (int k = 0; k < nw; k++) send_word(pw[k], k == nw - 1);
  endtask

  function automatic logic [15:0] rcomp();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF - 16'($urandom_range(0, 300));
      1:       return 16'h8000 + 16'($urandom_range(0, 300));
      default: return 16'($urandom);
    endcase
  endfunction

  // Builds pw[] for n samples and returns a consistent header.
  function automatic logic [63:0] make_pkt(input int n, input bit ht);
    logic [63:0] h;
    pw.delete();
    for (int k = 0; k < (n + 1) / 2; k++) pw.push_back({rcomp(), rcomp(), rcomp(), rcomp()});
    h = {$urandom, $urandom};
    h[61] = ht;
    h[47:32] = 16'(8 + 8 * int'(ht) + 4 * n);
    return h;
  endfunction

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while (sb.size() != 0 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d words outstanding want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic [63:0] h, ts;
    reset = 1'b1;
    set_stb = 1'b0;
    set_addr = '0;
    set_data = '0;
    i_tdata = '0;
    i_tlast = 1'b0;
    i_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (o_tvalid !== 1'b0 || o_tlast !== 1'b0 || o_tdata !== 64'h0 || i_tready !== 1'b0) begin
      bad++;
      $display("FAIL reset state: got v=%0b l=%0b d=%h rdy=%0b want 0/0/0/0", o_tvalid, o_tlast, o_tdata, i_tready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    // sc12, no timestamp
    write_reg(8'd1, 32'h1);
    pw = '{64'h12345678_9ABCDEF0, 64'h00110022_00330044};
    push_exp(64'h0000_0014_0000_0001, 1'b0);
    push_exp(64'h1235679A_BDEF0010, 1'b0);
    push_exp(64'h02003004_00000000, 1'b1);
    drive_pkt(64'h0000_0018_0000_0001, 64'h0, 1'b0);

    // sc8 truncate, same payload
    write_reg(8'd1, 32'h2);
    push_exp(64'h0000_0010_0000_0001, 1'b0);
    push_exp(64'h12569ADE_00000000, 1'b1);
    drive_pkt(64'h0000_0018_0000_0001, 64'h0, 1'b0);

    // sc8 round: 7FFF saturates, 1280->13, 8000->80, 0000->00
    write_reg(8'd1, 32'h6);
    pw = '{64'h7FFF1280_80000000};
    push_exp(64'h0000_000C_0000_0002, 1'b0);
    push_exp(64'h7F138000_00000000, 1'b1);
    drive_pkt(64'h0000_0010_0000_0002, 64'h0, 1'b0);

    // SID rewrite with timestamp; the mode write mid-packet must not affect this packet
    write_reg(8'd0, 32'h0001_FEED);
    write_reg(8'd1, 32'h1);
    pw = '{64'h01234567_89ABCDEF};
    h = 64'h2000_0018_DEADBEEF;
    ts = 64'h11223344_55667788;
    push_exp(64'h2000_0016_BEEFFEED, 1'b0);
    push_exp(ts, 1'b0);
    expect_pkt(h, ts);
    void'(sb.pop_front());
    void'(sb.pop_front());
    drive_pkt(h, ts, 1'b1);

    // header-only packet
    write_reg(8'd0, 32'h0);
    pw.delete();
    push_exp(64'h0000_0008_CAFE0001, 1'b1);
    drive_pkt(64'h0000_0008_CAFE0001, 64'h0, 1'b0);
    wait_drain();

    // sc12 sweep, len 12..40, with output backpressure
    bp_on = 1;
    write_reg(8'd1, 32'h1);
    for (int n = 1; n <= 8; n++) begin
      h = make_pkt(n, 1'b0);
      expect_pkt(h, 64'h0);
      drive_pkt(h, 64'h0, 1'b0);
    end
    wait_drain();

    // randomized packets and configuration
    gap_on = 1;
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 2) == 0) write_reg(8'd0, {15'h0, 1'($urandom), 16'($urandom)});
      write_reg(8'd1, {29'h0, 1'($urandom), 2'($urandom_range(0, 3))});
      h = make_pkt($urandom_range(0, 12), 1'($urandom));
      ts = {$urandom, $urandom};
      expect_pkt(h, ts);
      drive_pkt(h, ts, 1'b0);
    end
    wait_drain();

    // reset in the middle of a payload
    mon_en = 0;
    write_reg(8'd1, 32'h1);
    h = make_pkt(8, 1'b0);
    send_word(h, 1'b0);
    send_word(pw[0], 1'b0);
    send_word(pw[1], 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (o_tvalid !== 1'b0 || i_tready !== 1'b0) begin
      bad++;
      $display("FAIL mid reset: got v=%0b rdy=%0b want 0/0", o_tvalid, i_tready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    cfg_sid_en = 0;
    cfg_dest = '0;
    cfg_mode = '0;
    cfg_round = 0;
    mon_en = 1;
    for (int p = 0; p < 3; p++) begin
      write_reg(8'd1, {29'h0, 1'($urandom), 2'(p)});
      h = make_pkt(5 + p, 1'($urandom));
      ts = {$urandom, $urandom};
      expect_pkt(h, ts);
      drive_pkt(h, ts, 1'b0);
    end
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
